// File: rtl/drop_scheduler.sv
// Game-level spawn/retire controller for the falling-object slots.
// Owns the IDLE/PLAY/OVER game state, per-slot lifecycle, score, lives and the LFSR.
module drop_scheduler #(
    parameter int unsigned N            = 4,
    parameter int unsigned SPAWN_CYCLES = 25000000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N-1:0]      slot_point,
    input  logic [N-1:0]      slot_bottom,
    output logic [N-1:0]      slot_enable,
    output logic [N-1:0]      slot_reset,
    output logic [10*N-1:0]   slot_x,
    output logic [3*N-1:0]    slot_shape,
    output logic [3*N-1:0]    slot_color,
    output logic [10*N-1:0]   slot_speed,
    output logic [10*N-1:0]   slot_delay,
    output logic [9:0]        score,
    output logic [1:0]        lives,
    output logic              playing,
    output logic              game_over
);

    localparam int unsigned CNT_W = (SPAWN_CYCLES > 1) ? $clog2(SPAWN_CYCLES) : 1;
    localparam int unsigned CW    = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPAWN_CYCLES - 1);
    localparam logic [9:0]       SCORE_MAX = 10'd999;

    typedef enum logic [1:0] {G_IDLE, G_PLAY, G_OVER} game_e;
    typedef enum logic [1:0] {S_FREE, S_LOAD, S_ACTIVE, S_RETIRE} slot_e;

    game_e             game_q, game_d;
    slot_e             slot_q [N];
    slot_e             slot_d [N];
    logic [N-1:0]      caught_q, caught_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [9:0]        score_q, score_d;
    logic [1:0]        lives_q, lives_d;
    logic [N-1:0]      slot_enable_q, slot_enable_d;
    logic [N-1:0]      slot_reset_q, slot_reset_d;
    logic [10*N-1:0]   slot_x_q, slot_x_d;
    logic [3*N-1:0]    slot_shape_q, slot_shape_d;
    logic [3*N-1:0]    slot_color_q, slot_color_d;
    logic [10*N-1:0]   slot_speed_q, slot_speed_d;
    logic              playing_q, playing_d;
    logic              game_over_q, game_over_d;

    logic              in_play, stay_play, enter_play, spawn, taken;
    logic [1:0]        level;
    logic [9:0]        new_x, new_speed;
    logic [2:0]        new_shape, new_color;
    logic [CW-1:0]     n_catch, n_miss;
    logic [10:0]       score_sum;

    // Next-state for game, slots, counters and registered outputs
    always_comb begin
        game_d        = game_q;
        slot_d        = slot_q;
        caught_d      = caught_q;
        lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        score_d       = score_q;
        lives_d       = lives_q;
        slot_x_d      = slot_x_q;
        slot_shape_d  = slot_shape_q;
        slot_color_d  = slot_color_q;
        slot_speed_d  = slot_speed_q;
        taken         = 1'b0;
        n_catch       = '0;
        n_miss        = '0;
        score_sum     = '0;

        unique case (game_q)
            G_IDLE:  if (start) game_d = G_PLAY;
            G_PLAY:  if (lives_q == 2'd0) game_d = G_OVER;
            G_OVER:  if (start) game_d = G_PLAY;
            default: game_d = G_IDLE;
        endcase

        in_play    = (game_q == G_PLAY);
        stay_play  = in_play && (game_d == G_PLAY);
        enter_play = !in_play && (game_d == G_PLAY);
        spawn      = in_play && (cnt_q == CNT_LAST);
        cnt_d      = (stay_play && !spawn) ? cnt_q + CNT_W'(1) : '0;

        level     = (score_q >= 10'd24) ? 2'd3 : score_q[4:3];
        new_speed = 10'(3'd4 - 3'(level));
        new_x     = 10'(lfsr_q[8:0]) + 10'(lfsr_q[5:0]);
        new_shape = (lfsr_q[11:10] == 2'd3) ? 3'd0 : 3'(lfsr_q[11:10]);
        new_color = (lfsr_q[14:12] == 3'd0) ? 3'b111 : lfsr_q[14:12];

        for (int i = 0; i < N; i++) begin
            unique case (slot_q[i])
                S_FREE: begin
                    if (spawn && !taken) begin
                        slot_d[i] = S_LOAD;
                        taken     = 1'b1;
                    end
                end
                S_LOAD: begin
                    slot_d[i]               = S_ACTIVE;
                    slot_x_d[10*i +: 10]    = new_x;
                    slot_shape_d[3*i +: 3]  = new_shape;
                    slot_color_d[3*i +: 3]  = new_color;
                    slot_speed_d[10*i +: 10] = new_speed;
                end
                S_ACTIVE: begin
                    if (slot_point[i] || slot_bottom[i]) begin
                        slot_d[i]   = S_RETIRE;
                        caught_d[i] = slot_point[i];
                    end
                end
                default: begin
                    slot_d[i] = S_FREE;
                    if (caught_q[i]) n_catch = n_catch + CW'(1);
                    else             n_miss  = n_miss + CW'(1);
                end
            endcase
            if (game_d != G_PLAY) slot_d[i] = S_FREE;
        end

        // Retirements land one cycle after RETIRE is entered
        if (enter_play) begin
            score_d = '0;
            lives_d = 2'd3;
        end else if (in_play) begin
            score_sum = 11'(score_q) + 11'(n_catch);
            score_d   = (score_sum > 11'(SCORE_MAX)) ? SCORE_MAX : score_sum[9:0];
            lives_d   = (4'(n_miss) >= 4'(lives_q)) ? 2'd0 : lives_q - 2'(n_miss);
        end

        for (int i = 0; i < N; i++) begin
            slot_enable_d[i] = (slot_d[i] == S_ACTIVE);
            slot_reset_d[i]  = (slot_d[i] != S_ACTIVE);
        end
        playing_d   = (game_d == G_PLAY);
        game_over_d = (game_d == G_OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            game_q        <= G_IDLE;
            for (int i = 0; i < N; i++) slot_q[i] <= S_FREE;
            caught_q      <= '0;
            cnt_q         <= '0;
            lfsr_q        <= LFSR_SEED;
            score_q       <= '0;
            lives_q       <= 2'd3;
            slot_enable_q <= '0;
            slot_reset_q  <= '1;
            slot_x_q      <= '0;
            slot_shape_q  <= '0;
            slot_color_q  <= '0;
            slot_speed_q  <= {N{10'd4}};
            playing_q     <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            game_q        <= game_d;
            slot_q        <= slot_d;
            caught_q      <= caught_d;
            cnt_q         <= cnt_d;
            lfsr_q        <= lfsr_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
            slot_enable_q <= slot_enable_d;
            slot_reset_q  <= slot_reset_d;
            slot_x_q      <= slot_x_d;
            slot_shape_q  <= slot_shape_d;
            slot_color_q  <= slot_color_d;
            slot_speed_q  <= slot_speed_d;
            playing_q     <= playing_d;
            game_over_q   <= game_over_d;
        end
    end

    assign slot_enable = slot_enable_q;
    assign slot_reset  = slot_reset_q;
    assign slot_x      = slot_x_q;
    assign slot_shape  = slot_shape_q;
    assign slot_color  = slot_color_q;
    assign slot_speed  = slot_speed_q;
    assign slot_delay  = '0;
    assign score       = score_q;
    assign lives       = lives_q;
    assign playing     = playing_q;
    assign game_over   = game_over_q;

endmodule

// File: doc/drop_scheduler.md
# drop_scheduler

Game-level controller for the falling-object datapath: owns N falling-object slots, decides when each slot is launched, randomises its column, shape and colour, and sets its speed from the current level. It retires slots on catch or miss, and keeps score, lives and the IDLE/PLAY/OVER game state. It sits between the top-level game FSM/input logic and the array of falling-object instances, whose per-object rgb outputs are OR-ed elsewhere.

## Interface
- N, 4, number of object slots (1..8)
- SPAWN_CYCLES, 25000000, clk cycles between spawn attempts (≥2)
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level; starts/restarts a game from IDLE or OVER
- slot_point  in  N  per-slot caught flag from object instance (sticky until slot reset)
- slot_bottom  in  N  per-slot reached-bottom flag from object instance
- slot_enable  out  N  per-slot enable
- slot_reset  out  N  per-slot synchronous active-high clear for the instance
- slot_x  out  10*N  slot i column at [10i+9:10i]
- slot_shape  out  3*N  0 square, 1 ball, 2 triangle
- slot_color  out  3*N  rgb used for shape 0
- slot_speed  out  10*N  speed code (1 fastest)
- slot_delay  out  10*N  always 0
- score  out  10  catches, saturating at 999
- lives  out  2  remaining lives
- playing  out  1  high in PLAY
- game_over  out  1  high in OVER

## Operation
- Game FSM: IDLE → PLAY on start=1; PLAY → OVER when lives reaches 0; OVER → PLAY on start=1. Entering PLAY: score=0, lives=3, spawn counter=0, all slots FREE.
- Slot FSM per slot: FREE → LOAD → ACTIVE → RETIRE → FREE.
  - FREE: enable=0, reset=1.
  - LOAD (1 cycle): parameters registered, enable=0, reset=1.
  - ACTIVE: enable=1, reset=0.
  - RETIRE (1 cycle): enable=0, reset=1; score/lives update applied.
- Spawn: free-running counter in PLAY; at count==SPAWN_CYCLES-1 it wraps to 0 and the lowest-index FREE slot enters LOAD. If no slot is FREE, the spawn is dropped (not queued). At most one spawn per attempt.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clk in all states.
- LOAD parameter sampling, from the LFSR value at that cycle:
  - x = lfsr[8:0] + lfsr[5:0] (0..574).
  - shape = lfsr[11:10], with 3 mapped to 0.
  - color = lfsr[14:12], with 0 mapped to 3'b111.
  - speed = 4 − level, where level = min(score>>3, 3).
- Retire conditions for an ACTIVE slot:
  - slot_point=1 → RETIRE, score+1 (saturating at 999).
  - Else slot_bottom=1 → RETIRE, lives−1.
  - point has priority if both are high in the same cycle.
- Simultaneous retirements in one cycle: score adds the number of catches, saturating at 999. Lives subtracts the number of misses, floored at 0.
- Leaving PLAY: all slots forced to FREE the same cycle; spawn counter is held at 0. start in PLAY is ignored.
- Slot outputs are registered and keep their last values while FREE.

## Timing
- Reset (async assert, sync release) values:
  - game FSM IDLE; all slots FREE; slot_enable=0; slot_reset=all 1s.
  - slot_x/shape/color/delay=0; slot_speed=4.
  - score=0; lives=3; playing=0; game_over=0; LFSR=LFSR_SEED.
- start sampled at cycle t → playing=1 at t+1.
- Spawn fires at cycle t → slot in LOAD at t+1 → slot_enable=1 at t+2.
- ACTIVE slot sees slot_point=1 at cycle t → slot_enable=0 and RETIRE at t+1 → score updated at t+2, slot FREE at t+2.
- Miss dropping lives to 0 at cycle t+2 → game_over=1 and all slot_enable=0 at t+3.
- Reset asserted mid-game → all outputs return to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, then start=1 for one cycle with SPAWN_CYCLES=8 → playing=1 next cycle; slot 0 slot_enable=1 exactly 10 cycles after start; slot 1 enabled 8 cycles later.
- slot_point[0]=1 while slot 0 is ACTIVE → slot_reset[0]=1 next cycle, score=1 two cycles after; simultaneous point on slot 1 and slot 2 → score +2 in a single update.
- Three misses via slot_bottom → lives 3→2→1→0, game_over=1, all slot_enable=0; a later slot_bottom pulse changes nothing; start=1 → score=0, lives=3.
- slot_point and slot_bottom high together on one slot → score+1, lives unchanged.
- All N slots ACTIVE at a spawn attempt → no LOAD occurs, no slot parameter changes; a slot freed afterwards is used at the next attempt.
- Force score to 8 and 24, then spawn → slot_speed=3 and 1 respectively; score at 999 plus a catch → stays 999; every sampled slot_x ≤574, shape ≠3, color ≠0.
